det_engine_arbiter: RTL and testbench

Shares one 8x8 determinant engine (256-bit flat matrix of 4-bit entries, 32-bit signed result, Start/Ack handshake, one-hot state outputs) among NUM_REQ requesters. A round-robin arbiter grants one job at a time, latches the winner's matrix, and sequences the engine through Start and Ack. It returns the result with a per-requester response pulse and recovers a hung engine with a watchdog.

---
 rtl/det_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/det_engine_arbiter.sv | 117 +++++++++++
 tb/tb_det_engine_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared widths, arbiter state encoding and engine state-flag layout
// for the determinant-engine arbiter and the engine it drives.
package det_pkg;

    localparam int MAT_W  = 256;
    localparam int DET_W  = 32;
    localparam int WDOG_W = 14;

    localparam logic [5:0] ST_IDLE_OH  = 6'b000001;
    localparam logic [5:0] ST_LOAD_OH  = 6'b000010;
    localparam logic [5:0] ST_RUN_OH   = 6'b000100;
    localparam logic [5:0] ST_CAPT_OH  = 6'b001000;
    localparam logic [5:0] ST_RESP_OH  = 6'b010000;
    localparam logic [5:0] ST_ABORT_OH = 6'b100000;

    typedef enum logic [5:0] {
        ST_IDLE  = ST_IDLE_OH,
        ST_LOAD  = ST_LOAD_OH,
        ST_RUN   = ST_RUN_OH,
        ST_CAPT  = ST_CAPT_OH,
        ST_RESP  = ST_RESP_OH,
        ST_ABORT = ST_ABORT_OH
    } arb_state_t;

    // Engine state-flag bit order {Done,Comp,Load,Enter,I}
    localparam int FLG_I     = 0;
    localparam int FLG_ENTER = 1;
    localparam int FLG_LOAD  = 2;
    localparam int FLG_COMP  = 3;
    localparam int FLG_DONE  = 4;
    localparam int FLG_W     = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, searching cyclically.
// Purely combinational; one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    int               j;
    logic [IDX_W-1:0] jj;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/det_engine_arbiter.sv
// Shares one 8x8 determinant engine among NUM_REQ requesters: round-robin grant,
// Start/Ack sequencing, per-requester response pulse and a hung-engine watchdog.
module det_engine_arbiter
    import det_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 8192,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*MAT_W-1:0] req_mat,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic signed [DET_W-1:0]  resp_det,
    output logic                     resp_err,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     eng_Start,
    output logic                     eng_Ack,
    output logic                     eng_Reset,
    output logic [MAT_W-1:0]         eng_mat,
    input  logic signed [DET_W-1:0]  eng_det,
    input  logic                     eng_q_I,
    input  logic                     eng_q_Enter,
    input  logic                     eng_q_Done
);

    localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr, win_idx, nxt_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [MAT_W-1:0]   win_mat;
    logic [WDOG_W-1:0]  wdog;
    logic [FLG_W-1:0]   flags;
    logic               wd_expire;
    logic               flags_unused;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    always_comb begin
        win_mat = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) win_mat = req_mat[i*MAT_W +: MAT_W];
    end

    // The engine only needs to be observed at ENTER and DONE; the I flag is informational.
    assign flags        = {eng_q_Done, 1'b0, 1'b0, eng_q_Enter, eng_q_I};
    assign flags_unused = ^{flags[FLG_I], flags[FLG_LOAD], flags[FLG_COMP]};

    assign nxt_ptr   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    assign wd_expire = (wdog >= WD_LAST);
    assign busy      = (state != ST_IDLE);
    // Start is withheld on the expiry cycle so an aborting job never kicks the engine.
    assign eng_Start = (state == ST_LOAD) && flags[FLG_ENTER] && !wd_expire;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            resp_valid <= '0;
            resp_det   <= '0;
            resp_err   <= 1'b0;
            eng_Ack    <= 1'b0;
            eng_mat    <= '0;
            eng_Reset  <= 1'b1;
            wdog       <= '0;
        end else begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            eng_Reset  <= 1'b0;
            unique case (state)
                ST_IDLE: if (|gnt) begin
                    grant_id <= win_idx;
                    rr_ptr   <= nxt_ptr;
                    eng_mat  <= win_mat;
                    wdog     <= '0;
                    state    <= ST_LOAD;
                end
                ST_LOAD, ST_RUN: begin
                    if (wdog != '1) wdog <= wdog + WDOG_W'(1);
                    if (wd_expire) begin
                        eng_Reset  <= 1'b1;
                        resp_valid <= NUM_REQ'(1) << grant_id;
                        resp_err   <= 1'b1;
                        resp_det   <= '0;
                        state      <= ST_ABORT;
                    end else if (state == ST_LOAD && flags[FLG_ENTER]) begin
                        state <= ST_RUN;
                    end else if (state == ST_RUN && flags[FLG_DONE]) begin
                        state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    resp_det   <= eng_det;
                    resp_valid <= NUM_REQ'(1) << grant_id;
                    eng_Ack    <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: if (!flags[FLG_DONE]) begin
                    eng_Ack <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_ABORT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_det_engine_arbiter.sv
// Bench for det_engine_arbiter: behavioural engine stand-in, round-robin reference
// model and scenario tasks with inline comparisons.
module tb_det_engine_arbiter;

    localparam int NR = 4;
    localparam int TO = 64;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*256-1:0] req_mat = '0;
    logic [NR-1:0]     resp_valid;
    logic signed [31:0] resp_det;
    logic              resp_err, busy;
    logic [1:0]        grant_id;
    logic              eng_Start, eng_Ack, eng_Reset;
    logic [255:0]      eng_mat;
    logic signed [31:0] eng_det = '0;
    logic              eng_q_I, eng_q_Enter, eng_q_Done;

    det_engine_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_mat(req_mat),
        .resp_valid(resp_valid), .resp_det(resp_det), .resp_err(resp_err),
        .busy(busy), .grant_id(grant_id), .eng_Start(eng_Start), .eng_Ack(eng_Ack),
        .eng_Reset(eng_Reset), .eng_mat(eng_mat), .eng_det(eng_det),
        .eng_q_I(eng_q_I), .eng_q_Enter(eng_q_Enter), .eng_q_Done(eng_q_Done)
    );

    always #5 Clk = ~Clk;

    int total = 0, bad = 0;
    int exp_det [NR];

    // Determinant of a triangular matrix is the product of its diagonal.
    function automatic logic signed [31:0] diag_prod(input logic [255:0] m);
        int p = 1;
        for (int r = 0; r < 8; r++) p = p * int'(m[r*36 +: 4]);
        return p;
    endfunction

    function automatic logic [255:0] mk_mat(input logic [31:0] dg, input bit fill);
        logic [255:0] m = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (r == c) m[(r*8+c)*4 +: 4] = dg[r*4 +: 4];
                else if (fill && c > r) m[(r*8+c)*4 +: 4] = 4'($urandom_range(0, 15));
        return m;
    endfunction

    // Engine stand-in: I -> ENTER, Start -> LOAD -> COMP (eng_lat+1 cycles) -> DONE until Ack.
    typedef enum int {E_I, E_ENTER, E_LOAD, E_COMP, E_DONE} est_t;
    est_t est = E_I;
    int   ecnt = 0, eng_lat = 3;
    bit   stall = 1'b0;

    assign eng_q_I     = (est == E_I);
    assign eng_q_Enter = (est == E_ENTER);
    assign eng_q_Done  = (est == E_DONE);

    always @(posedge Clk) begin
        if (eng_Reset === 1'b1) est <= E_I;
        else case (est)
            E_I:     est <= E_ENTER;
            E_ENTER: if (eng_Start === 1'b1) est <= E_LOAD;
            E_LOAD:  begin est <= E_COMP; ecnt <= eng_lat; end
            E_COMP:  if (!stall) begin
                if (ecnt == 0) begin est <= E_DONE; eng_det <= diag_prod(eng_mat); end
                else ecnt <= ecnt - 1;
            end
            E_DONE:  if (eng_Ack === 1'b1) est <= E_I;
            default: est <= E_I;
        endcase
    end

    int cyc = 0, done_cyc = 0, resp_cyc = 0, start_cnt = 0;
    int pulses [NR] = '{default: 0};
    bit done_q = 1'b0;

    always @(posedge Clk) begin
        #1;
        cyc++;
        if (eng_q_Done && !done_q) done_cyc = cyc;
        done_q = eng_q_Done;
        if (eng_Start === 1'b1) start_cnt++;
        for (int i = 0; i < NR; i++) if (resp_valid[i] === 1'b1) pulses[i]++;
        if (resp_valid != '0) resp_cyc = cyc;
        if (!Reset && cyc > 3) begin
            total++;
            if ((eng_Start && eng_Ack) || !$onehot0(resp_valid) || (resp_err && resp_valid == '0)) begin
                bad++;
                $display("FAIL invariant cyc=%0d: start=%b ack=%b resp_valid=%b err=%b, want no start+ack, onehot0 valid, err only with valid",
                         cyc, eng_Start, eng_Ack, resp_valid, resp_err);
            end
        end
    end

    task automatic set_mat(input int i, input logic [255:0] m);
        req_mat[i*256 +: 256] = m;
    endtask

    task automatic wait_resp(input int budget, output int who, output logic signed [31:0] d,
                             output logic e, output bit ok);
        ok = 1'b0; who = -1; d = '0; e = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge Clk);
            if (resp_valid != '0) begin
                ok = 1'b1; d = resp_det; e = resp_err;
                for (int i = 0; i < NR; i++) if (resp_valid[i]) who = i;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; req = '0;
        repeat (3) @(negedge Clk);
        total++;
        if ({busy, resp_valid, resp_err, eng_Start, eng_Ack, eng_Reset} !== 9'b000000001) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b valid=%b err=%b start=%b ack=%b engrst=%b, want 0 0000 0 0 0 1",
                     busy, resp_valid, resp_err, eng_Start, eng_Ack, eng_Reset);
        end
        total++;
        if (resp_det !== 0 || eng_mat !== '0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: det=%0d mat=%h gid=%0d, want 0 0 0", resp_det, eng_mat, grant_id);
        end
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if (eng_Reset !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: engrst=%b busy=%b, want 0 0", eng_Reset, busy);
        end
    endtask

    task automatic test_single();
        int who, s0, p0; logic signed [31:0] d; logic e; bit ok;
        set_mat(2, mk_mat(32'h11111111, 1'b0));
        s0 = start_cnt; p0 = pulses[2];
        req = 4'b0100;
        @(negedge Clk);
        total++;
        if (busy !== 1'b1 || grant_id !== 2'd2 || eng_Start !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: busy=%b gid=%0d start=%b, want 1 2 1", busy, grant_id, eng_Start);
        end
        wait_resp(40, who, d, e, ok);
        req = '0;
        total++;
        if (!ok || who !== 2 || d !== 1 || e !== 1'b0) begin
            bad++;
            $display("FAIL single_resp: ok=%0d who=%0d det=%0d err=%b, want who=2 det=1 err=0", ok, who, d, e);
        end
        total++;
        if (resp_cyc - done_cyc !== 2) begin
            bad++;
            $display("FAIL single_latency: %0d cycles after done, want 2", resp_cyc - done_cyc);
        end
        repeat (4) @(negedge Clk);
        total++;
        if (pulses[2] - p0 !== 1 || start_cnt - s0 !== 1 || eng_mat !== mk_mat(32'h11111111, 1'b0)) begin
            bad++;
            $display("FAIL single_counts: pulses=%0d starts=%0d mat_ok=%b, want 1 1 1",
                     pulses[2] - p0, start_cnt - s0, eng_mat === mk_mat(32'h11111111, 1'b0));
        end
    endtask

    task automatic test_contention();
        int who; logic signed [31:0] d; logic e; bit ok;
        Reset = 1'b1;
        for (int i = 0; i < NR; i++) set_mat(i, mk_mat(32'h22222222, 1'b1));
        req = 4'b1111;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_resp(60, who, d, e, ok);
            total++;
            if (!ok || who !== j % NR || d !== 256 || e !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL contention_job%0d: ok=%0d who=%0d det=%0d err=%b busy=%b, want who=%0d det=256 err=0 busy=1",
                         j, ok, who, d, e, busy, j % NR);
            end
            if (!ok) break;
            if (j == 4) req = '0;
            else req[who] = 1'b0;
            @(negedge Clk);
            if (j < 4) req[who] = 1'b1;
        end
        req = '0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        int who, idle; logic signed [31:0] d; logic e; bit ok;
        set_mat(1, '0);
        set_mat(3, mk_mat(32'h11111111, 1'b1));
        req = 4'b1010;
        wait_resp(40, who, d, e, ok);
        req[1] = 1'b0;
        total++;
        if (!ok || who !== 1 || d !== 0 || e !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: ok=%0d who=%0d det=%0d err=%b, want who=1 det=0 err=0", ok, who, d, e);
        end
        idle = 0;
        for (int k = 0; k < 20 && !(idle > 0 && busy); k++) begin
            @(negedge Clk);
            if (!busy) idle++;
        end
        total++;
        if (idle !== 1) begin
            bad++;
            $display("FAIL b2b_idle_gap: %0d idle cycles, want 1", idle);
        end
        wait_resp(40, who, d, e, ok);
        req = '0;
        total++;
        if (!ok || who !== 3 || d !== 1 || e !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: ok=%0d who=%0d det=%0d err=%b, want who=3 det=1 err=0", ok, who, d, e);
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_timeout();
        int who, lc; logic signed [31:0] d; logic e; bit ok;
        stall = 1'b1;
        set_mat(0, mk_mat(32'h11111111, 1'b0));
        req = 4'b0001;
        @(negedge Clk);
        lc = cyc;
        wait_resp(TO + 20, who, d, e, ok);
        req = '0;
        total++;
        if (!ok || who !== 0 || d !== 0 || e !== 1'b1) begin
            bad++;
            $display("FAIL timeout_resp: ok=%0d who=%0d det=%0d err=%b, want who=0 det=0 err=1", ok, who, d, e);
        end
        total++;
        if (eng_Reset !== 1'b1 || resp_cyc - lc !== TO) begin
            bad++;
            $display("FAIL timeout_abort: engrst=%b cycles=%0d, want 1 %0d", eng_Reset, resp_cyc - lc, TO);
        end
        stall = 1'b0;
        @(negedge Clk);
        total++;
        if (eng_Reset !== 1'b0 || resp_valid !== '0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_width: engrst=%b valid=%b err=%b, want 0 0000 0", eng_Reset, resp_valid, resp_err);
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset_mid_run();
        int who, p2; logic signed [31:0] d; logic e; bit ok;
        eng_lat = 20;
        set_mat(2, mk_mat(32'h11111111, 1'b0));
        req = 4'b0100;
        repeat (5) @(negedge Clk);
        p2 = pulses[2];
        Reset = 1'b1; req = '0;
        repeat (2) @(negedge Clk);
        total++;
        if ({busy, resp_valid, resp_err, eng_Start, eng_Ack, eng_Reset} !== 9'b000000001 ||
            resp_det !== 0 || eng_mat !== '0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL midreset_state: busy=%b valid=%b err=%b start=%b ack=%b engrst=%b det=%0d gid=%0d, want reset values",
                     busy, resp_valid, resp_err, eng_Start, eng_Ack, eng_Reset, resp_det, grant_id);
        end
        Reset = 1'b0; eng_lat = 3;
        repeat (30) @(negedge Clk);
        total++;
        if (pulses[2] !== p2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_dropped: extra pulses=%0d busy=%b, want 0 0", pulses[2] - p2, busy);
        end
        set_mat(1, mk_mat(32'h22222222, 1'b0));
        req = 4'b0010;
        wait_resp(40, who, d, e, ok);
        req = '0;
        total++;
        if (!ok || who !== 1 || d !== 256 || e !== 1'b0) begin
            bad++;
            $display("FAIL midreset_next: ok=%0d who=%0d det=%0d err=%b, want who=1 det=256 err=0", ok, who, d, e);
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_early_drop();
        int who, p0; logic signed [31:0] d; logic e; bit ok;
        set_mat(0, mk_mat(32'h11111113, 1'b1));
        p0 = pulses[0];
        req = 4'b0001;
        @(negedge Clk);
        @(negedge Clk);
        req = '0;
        wait_resp(40, who, d, e, ok);
        total++;
        if (!ok || who !== 0 || d !== 3 || e !== 1'b0) begin
            bad++;
            $display("FAIL drop_resp: ok=%0d who=%0d det=%0d err=%b, want who=0 det=3 err=0", ok, who, d, e);
        end
        repeat (5) @(negedge Clk);
        total++;
        if (pulses[0] - p0 !== 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_pulses: pulses=%0d busy=%b, want 1 0", pulses[0] - p0, busy);
        end
    endtask

    task automatic new_job(input int i);
        logic [31:0] dg;
        int prod, v;
        dg = '0; prod = 1;
        for (int r = 0; r < 8; r++) begin
            v = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
            dg[r*4 +: 4] = 4'(v);
            prod = prod * v;
        end
        set_mat(i, mk_mat(dg, 1'b1));
        exp_det[i] = prod;
    endtask

    task automatic test_random();
        int who, ptr, expw; logic signed [31:0] d; logic e; bit ok;
        logic [NR-1:0] pend, add;
        Reset = 1'b1; req = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        ptr = 0;
        pend = NR'($urandom_range(1, 15));
        for (int i = 0; i < NR; i++) if (pend[i]) new_job(i);
        req = pend;
        for (int j = 0; j < 24; j++) begin
            expw = -1;
            for (int k = NR - 1; k >= 0; k--) if (pend[(ptr + k) % NR]) expw = (ptr + k) % NR;
            wait_resp(60, who, d, e, ok);
            total++;
            if (!ok || who !== expw || d !== exp_det[expw] || e !== 1'b0) begin
                bad++;
                $display("FAIL random_job%0d: ok=%0d who=%0d det=%0d err=%b, want who=%0d det=%0d err=0",
                         j, ok, who, d, e, expw, exp_det[expw]);
            end
            if (!ok || who < 0) break;
            pend[who] = 1'b0;
            ptr = (who + 1) % NR;
            add = NR'($urandom_range(0, 15));
            if ((pend | add) == '0) add[$urandom_range(0, NR - 1)] = 1'b1;
            for (int i = 0; i < NR; i++) if (add[i] && !pend[i]) begin new_job(i); pend[i] = 1'b1; end
            req = pend;
        end
        req = '0;
        repeat (6) @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        test_early_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
